// File: rtl/colour_conversion_controller_if.sv
// colour_conversion_controller_if
//   Groups the signals between the frame sequencer and the surrounding
//   blocks: the start/done handshake, the single-port SRAM address and
//   write-enable, and the datapath control strobes.
//   master : the controller (drives the address/enables, reads start/eop)
//   slave  : the top level / SRAM / datapath side
//   Optional macro COLOUR_CONV_STALL_EN adds mem_gnt (memory arbitration grant).
interface colour_conversion_controller_if #(
  parameter int ADDR_W = 18
);
  logic              start;
  logic              end_of_pixel;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic              Yen_odd;
  logic              Yen_even;
  logic              Uen_odd;
  logic              Uen_even;
  logic              Ven_odd;
  logic              Ven_even;
  logic              Smux1;
  logic [1:0]        Smux2;
  logic              Temp_en;
  logic              Cen;
`ifdef COLOUR_CONV_STALL_EN
  logic              mem_gnt;
`endif

  modport master (
    input  start, end_of_pixel,
`ifdef COLOUR_CONV_STALL_EN
    input  mem_gnt,
`endif
    output busy, done, mem_addr, mem_wen,
    output Yen_odd, Yen_even, Uen_odd, Uen_even, Ven_odd, Ven_even,
    output Smux1, Smux2, Temp_en, Cen
  );

  modport slave (
    output start, end_of_pixel,
`ifdef COLOUR_CONV_STALL_EN
    output mem_gnt,
`endif
    input  busy, done, mem_addr, mem_wen,
    input  Yen_odd, Yen_even, Uen_odd, Uen_even, Ven_odd, Ven_even,
    input  Smux1, Smux2, Temp_en, Cen
  );
endinterface

// File: rtl/colour_conversion_controller.sv
// colour_conversion_controller
//   Frame sequencer for the YUV->RGB datapath. For each pixel pair p it
//   reads the packed Y, U, V words, steps the datapath through the R, G and
//   B computations (even pixel into Temp, then the odd pixel alongside it),
//   writes each packed result word back and bumps the datapath pair counter.
//   11 cycles per pair when memory is always granted.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - colour_conversion_controller_if.master: start/end_of_pixel in,
//          busy/done, mem_addr/mem_wen, datapath enables and mux selects out
// Options:
//   COLOUR_CONV_STALL_EN - memory accesses wait for bus.mem_gnt
module colour_conversion_controller #(
  parameter int ADDR_W = 18,
  parameter int PAIRS  = 38400,
  parameter int Y_BASE = 0,
  parameter int U_BASE = 38400,
  parameter int V_BASE = 76800,
  parameter int R_BASE = 115200,
  parameter int G_BASE = 153600,
  parameter int B_BASE = 192000
) (
  input  logic                          clk,
  input  logic                          rst,
  colour_conversion_controller_if.master bus
);

  localparam logic [ADDR_W-1:0] PAIRS_A = ADDR_W'(PAIRS);
  localparam logic [ADDR_W-1:0] Y_A     = ADDR_W'(Y_BASE);
  localparam logic [ADDR_W-1:0] U_A     = ADDR_W'(U_BASE);
  localparam logic [ADDR_W-1:0] V_A     = ADDR_W'(V_BASE);
  localparam logic [ADDR_W-1:0] R_A     = ADDR_W'(R_BASE);
  localparam logic [ADDR_W-1:0] G_A     = ADDR_W'(G_BASE);
  localparam logic [ADDR_W-1:0] B_A     = ADDR_W'(B_BASE);

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_U, RD_V, CAP_V,
    CALC_R, WR_R, CALC_G, WR_G, CALC_B, WR_B,
    CHECK, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] p, p_n;
  logic              gnt;   // memory access in this cycle is accepted
  logic              cap;   // read data of the previous access is on R_data

`ifdef COLOUR_CONV_STALL_EN
  // A held read state must only capture once: the SRAM returns data in the
  // cycle right after the granted address cycle, which is the first cycle
  // of the following state. fresh marks that first cycle.
  logic fresh;
  assign gnt = bus.mem_gnt;
  assign cap = fresh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fresh <= 1'b0;
    else     fresh <= (state_n != state);
  end
`else
  assign gnt = 1'b1;
  assign cap = 1'b1;
`endif

  // state and pair index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
    end
  end

  // next state / pair index
  always_comb begin
    state_n = state;
    p_n     = p;
    case (state)
      IDLE:   if (bus.start) state_n = RD_Y;
      RD_Y:   if (gnt) state_n = RD_U;
      RD_U:   if (gnt) state_n = RD_V;
      RD_V:   if (gnt) state_n = CAP_V;
      CAP_V:  state_n = CALC_R;
      CALC_R: state_n = WR_R;
      WR_R:   if (gnt) state_n = CALC_G;
      CALC_G: state_n = WR_G;
      WR_G:   if (gnt) state_n = CALC_B;
      CALC_B: state_n = WR_B;
      WR_B: begin
        if (gnt) begin
          state_n = CHECK;
          p_n     = p + 1'b1;
        end
      end
      // the local count ends the frame even if the datapath flag never rises
      CHECK:  state_n = (bus.end_of_pixel || p >= PAIRS_A) ? DONE : RD_Y;
      DONE: begin
        state_n = IDLE;
        p_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore output decode (Cen additionally qualified by the grant when stalls exist)
  logic              busy_c, done_c, wen_c, yen_c, uen_c, ven_c;
  logic              smux1_c, temp_c, cen_c;
  logic [1:0]        smux2_c;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    busy_c  = (state != IDLE);
    done_c  = 1'b0;
    wen_c   = 1'b0;
    yen_c   = 1'b0;
    uen_c   = 1'b0;
    ven_c   = 1'b0;
    smux1_c = 1'b0;
    smux2_c = 2'd0;
    temp_c  = 1'b0;
    cen_c   = 1'b0;
    addr_c  = '0;
    case (state)
      RD_Y:   addr_c = Y_A + p;
      RD_U: begin
        addr_c = U_A + p;
        yen_c  = cap;
      end
      RD_V: begin
        addr_c = V_A + p;
        uen_c  = cap;
      end
      CAP_V:  ven_c = cap;
      // CALC_x latches the even result into Temp; WR_x then selects the odd
      // pixel so the written word is {even, odd}.
      CALC_R: temp_c = 1'b1;
      WR_R: begin
        smux1_c = 1'b1;
        addr_c  = R_A + p;
        wen_c   = 1'b1;
      end
      CALC_G: begin
        smux2_c = 2'd1;
        temp_c  = 1'b1;
      end
      WR_G: begin
        smux1_c = 1'b1;
        smux2_c = 2'd1;
        addr_c  = G_A + p;
        wen_c   = 1'b1;
      end
      CALC_B: begin
        smux2_c = 2'd2;
        temp_c  = 1'b1;
      end
      WR_B: begin
        smux1_c = 1'b1;
        smux2_c = 2'd2;
        addr_c  = B_A + p;
        wen_c   = 1'b1;
        cen_c   = gnt;
      end
      DONE:   done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.mem_addr = addr_c;
  assign bus.mem_wen  = wen_c;
  assign bus.Yen_odd  = yen_c;
  assign bus.Yen_even = yen_c;
  assign bus.Uen_odd  = uen_c;
  assign bus.Uen_even = uen_c;
  assign bus.Ven_odd  = ven_c;
  assign bus.Ven_even = ven_c;
  assign bus.Smux1    = smux1_c;
  assign bus.Smux2    = smux2_c;
  assign bus.Temp_en  = temp_c;
  assign bus.Cen      = cen_c;

endmodule

// File: tb/tb_colour_conversion_controller.sv
// tb_colour_conversion_controller
//   Directed bench for the frame sequencer with PAIRS = 2. Expected control
//   words and addresses come from a hand-written per-state table.
module tb_colour_conversion_controller;

  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  colour_conversion_controller_if #(.ADDR_W(ADDR_W)) bus ();

  colour_conversion_controller #(
    .ADDR_W(ADDR_W), .PAIRS(2),
    .Y_BASE(0), .U_BASE(38400), .V_BASE(76800),
    .R_BASE(115200), .G_BASE(153600), .B_BASE(192000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {mem_wen, Yo, Ye, Uo, Ue, Vo, Ve, Smux1, Smux2[1:0], Temp_en, Cen}
  logic [11:0] ctrl;
  assign ctrl = {bus.mem_wen, bus.Yen_odd, bus.Yen_even, bus.Uen_odd, bus.Uen_even,
                 bus.Ven_odd, bus.Ven_even, bus.Smux1, bus.Smux2, bus.Temp_en, bus.Cen};

  // expected per state of a pair: RD_Y..CHECK
  logic [11:0] exp_ctrl [11] = '{12'h000, 12'h600, 12'h180, 12'h060, 12'h002,
                                 12'h810, 12'h006, 12'h814, 12'h00A, 12'h819, 12'h000};
  int          exp_base [11] = '{0, 38400, 76800, -1, -1, 115200, -1, 153600, -1, 192000, -1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Run one frame from a start pulse. eop_k > 0 raises end_of_pixel in
  // cycle eop_k (visible from the next cycle); poke pulses start in RD_V.
  task automatic run_frame(input string name, input int eop_k, input bit poke);
    int done_k;
    done_k = (eop_k > 0 && eop_k < 11) ? 12 : 23;
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k < done_k) begin
        int st, pr, ea;
        st = (k - 1) % 11;
        pr = (k - 1) / 11;
        ea = (exp_base[st] < 0) ? 0 : exp_base[st] + pr;
        chk($sformatf("%s k%0d ctrl", name, k), 32'(ctrl), 32'(exp_ctrl[st]));
        chk($sformatf("%s k%0d addr", name, k), 32'(bus.mem_addr), 32'(ea));
        chk($sformatf("%s k%0d busy/done", name, k), {bus.busy, bus.done}, 32'b10);
      end else if (k == done_k) begin
        chk($sformatf("%s done pulse", name), {bus.busy, bus.done, ctrl}, {2'b11, 12'h000});
        chk($sformatf("%s done addr", name), 32'(bus.mem_addr), 32'd0);
      end else begin
        chk($sformatf("%s idle after", name), {bus.busy, bus.done, ctrl}, 32'd0);
      end
      if (poke && k == 3) bus.start = 1'b1;
      if (poke && k == 4) bus.start = 1'b0;
      if (k == eop_k) bus.end_of_pixel = 1'b1;
    end
    bus.end_of_pixel = 1'b0;
  endtask

  initial begin
    bus.start        = 1'b1;   // must be ignored while in reset
    bus.end_of_pixel = 1'b0;
`ifdef COLOUR_CONV_STALL_EN
    bus.mem_gnt      = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("in reset", {bus.busy, bus.done, ctrl}, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d ctrl", i), {bus.busy, bus.done, ctrl}, 32'd0);
      chk($sformatf("idle%0d addr", i), 32'(bus.mem_addr), 32'd0);
    end

    // two pairs, end_of_pixel after the second Cen (WR_B of pair 1 is k=21)
    run_frame("eop2", 21, 1'b0);
    // no end_of_pixel: internal count ends the frame; start during RD_V ignored
    run_frame("cnt", 0, 1'b1);
    // end_of_pixel early: frame ends after the first pair
    run_frame("eop1", 10, 1'b0);

    // reset during WR_G of pair 0 (k=8)
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre-rst wen", {31'd0, bus.mem_wen}, 32'd1);
    chk("pre-rst addr", 32'(bus.mem_addr), 32'd153600);
    #1 rst = 1'b1;
    #1;
    chk("async rst", {bus.busy, bus.done, ctrl}, 32'd0);
    chk("async rst addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst%0d", i), {bus.busy, bus.done, ctrl}, 32'd0);
    end
    run_frame("fresh", 0, 1'b0);

`ifdef COLOUR_CONV_STALL_EN
    begin
      int addr_u = 0, uen_n = 0, cen_k = 0, yen_n = 0;
      bit seen_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.mem_addr == 18'd38400) addr_u++;
        if (bus.Uen_odd) uen_n++;
        if (bus.Yen_odd) yen_n++;
        if (bus.Cen) cen_k = k;
        if (k == 2) bus.mem_gnt = 1'b0;
        if (k == 5) bus.mem_gnt = 1'b1;
      end
      chk("stall U addr cycles", 32'(addr_u), 32'd4);
      chk("stall Uen pulses", 32'(uen_n), 32'd1);
      chk("stall Yen pulses", 32'(yen_n), 32'd1);
      chk("stall Cen cycle", 32'(cen_k), 32'd13);
      for (int i = 0; i < 40 && !seen_done; i++) begin
        @(negedge clk);
        if (bus.done) seen_done = 1'b1;
      end
      chk("stall frame done", {31'd0, seen_done}, 32'd1);
      @(negedge clk);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
